// File: rtl/seq_multiplier_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seq_multiplier_pkg
//  Purpose  : Shared definitions for the sequential shift-and-add multiplier.
//             - FSM state encoding.
//             - Default operand widths, shared with the restoring divider so
//               that the divider self-check path sees identical widths.
//             - Iteration-counter width.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package seq_multiplier_pkg;

    // Default widths, identical to the companion divider.
    // M: quotient / multiplicand width.  N: divisor and remainder width.
    localparam int M_DEFAULT = 26;
    localparam int N_DEFAULT = 14;

    // Iteration counter width for the default multiplicand width.
    localparam int CNT_W = $clog2(M_DEFAULT);

    // Counter width for an arbitrary multiplicand width; never narrower
    // than one bit.
    function automatic int cnt_width(input int m);
        return (m > 1) ? $clog2(m) : 1;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_ADD  = 2'd2
    } state_e;

endpackage
`default_nettype wire

// File: rtl/seq_multiplier_mul_step.sv
`default_nettype none
// ============================================================================
//  Module   : mul_step
//  Purpose  : One combinational shift-and-add step of the MSB-first
//             multiplier: acc_o = (acc_i << 1) + (mbit_i ? addend_i : 0).
//             Has the same shape as one step of the restoring divider, so
//             it can later be replicated into an unrolled, pipelined variant.
//  Ports    : acc_i    [ACC_W-1:0]  running accumulator
//             mbit_i                current multiplicand bit (MSB first)
//             addend_i [ADD_W-1:0]  divisor (multiplier) operand
//             acc_o    [ACC_W-1:0]  next accumulator value
//  Revision : 1.0 - initial release
// ============================================================================
module mul_step #(
    parameter int ACC_W = 40,
    parameter int ADD_W = 14
) (
    input  logic [ACC_W-1:0] acc_i,
    input  logic             mbit_i,
    input  logic [ADD_W-1:0] addend_i,
    output logic [ACC_W-1:0] acc_o
);

    logic [ACC_W-1:0] addend_ext;

    assign addend_ext = mbit_i ? {{(ACC_W-ADD_W){1'b0}}, addend_i} : '0;

    // The MSB shifted out is always zero: the partial product after k
    // steps is below 2^(k+ADD_W), which never exceeds ACC_W bits.
    assign acc_o = {acc_i[ACC_W-2:0], 1'b0} + addend_ext;

endmodule
`default_nettype wire

// File: rtl/seq_multiplier.sv
`default_nettype none
// ============================================================================
//  Module   : seq_multiplier
//  Purpose  : Iterative shift-and-add multiplier. Computes
//             product = quotient * divisor + remainder,
//             one multiplicand bit per clock, MSB first. This rebuilds the
//             dividend from the restoring divider's outputs. The result and
//             rem_err are held until the next accepted start.
//  Ports    : clk                 system clock, rising edge
//             rst                 synchronous reset, active-high
//             start               request, accepted only while ready=1
//             quotient  [M-1:0]   multiplicand, captured on accepted start
//             divisor   [N-1:0]   multiplier, captured on accepted start
//             remainder [N-1:0]   addend, captured on accepted start
//             ready               high in IDLE
//             done                one-cycle pulse when product is valid
//             product   [M+N-1:0] quotient*divisor + remainder
//             rem_err             remainder >= divisor for the last result
//  Revision : 1.0 - initial release
// ============================================================================
module seq_multiplier
    import seq_multiplier_pkg::*;
#(
    parameter int M = M_DEFAULT,
    parameter int N = N_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [M-1:0]   quotient,
    input  logic [N-1:0]   divisor,
    input  logic [N-1:0]   remainder,
    output logic           ready,
    output logic           done,
    output logic [M+N-1:0] product,
    output logic           rem_err
);

    localparam int W  = M + N;
    // The default configuration takes the shared counter width so it
    // tracks the divider exactly; other widths derive their own.
    localparam int CW = (M == M_DEFAULT) ? CNT_W : cnt_width(M);

    state_e          state_q, state_d;
    logic [W-1:0]    acc_q, acc_d;
    logic [M-1:0]    mcand_q, mcand_d;
    logic [N-1:0]    div_q, div_d;
    logic [N-1:0]    rem_q, rem_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    prod_q, prod_d;
    logic            err_q, err_d;
    logic            done_q, done_d;

    logic [W-1:0]    step_acc;

    mul_step #(
        .ACC_W (W),
        .ADD_W (N)
    ) u_mul_step (
        .acc_i    (acc_q),
        .mbit_i   (mcand_q[M-1]),
        .addend_i (div_q),
        .acc_o    (step_acc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            mcand_q <= '0;
            div_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            prod_q  <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            div_q   <= div_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        mcand_d = mcand_q;
        div_d   = div_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        err_d   = err_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mcand_d = quotient;
                    div_d   = divisor;
                    rem_d   = remainder;
                    acc_d   = '0;
                    cnt_d   = CW'(M - 1);
                    state_d = ST_RUN;
                end
            end

            // One step per edge; the step taken while cnt_q is zero is the
            // M-th and last one.
            ST_RUN: begin
                acc_d   = step_acc;
                mcand_d = mcand_q << 1;
                if (cnt_q == '0) begin
                    state_d = ST_ADD;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end

            // The sum cannot overflow: the largest result is 2^W - 2^M.
            ST_ADD: begin
                prod_d  = acc_q + {{M{1'b0}}, rem_q};
                err_d   = (rem_q >= div_q);
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign ready   = (state_q == ST_IDLE);
    assign done    = done_q;
    assign product = prod_q;
    assign rem_err = err_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_multiplier.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_multiplier
//  Purpose  : Self-checking bench for seq_multiplier. Checks table vectors,
//             the busy / back-to-back / reset corner sequences, random
//             operands against an arithmetic model, and a divider round
//             trip (dividend -> quotient, remainder -> product).
//  Ports    : none
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_seq_multiplier;
    import seq_multiplier_pkg::*;

    localparam int M = M_DEFAULT;
    localparam int N = N_DEFAULT;
    localparam int W = M + N;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [M-1:0] quotient;
    logic [N-1:0] divisor;
    logic [N-1:0] remainder;
    logic         ready;
    logic         done;
    logic [W-1:0] product;
    logic         rem_err;

    seq_multiplier #(.M(M), .N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .quotient  (quotient),
        .divisor   (divisor),
        .remainder (remainder),
        .ready     (ready),
        .done      (done),
        .product   (product),
        .rem_err   (rem_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [M-1:0] q;
        logic [N-1:0] d;
        logic [N-1:0] r;
        logic [W-1:0] p;
        logic         e;
    } vec_t;

    vec_t         tbl [7];
    int           n_checks = 0;
    int           n_fail   = 0;
    logic [W-1:0] last_p;     // model of the result currently held
    logic [31:0]  t32;
    logic [31:0]  a32;
    logic [31:0]  b32;
    logic [M-1:0] rq;
    logic [N-1:0] rd;
    logic [N-1:0] rr;
    logic [63:0]  e64;
    bit           flag;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Called at a negedge with start already driven. Iteration k observes
    // the cycle after edge E_k (E0 = start edge). Inputs are scrambled
    // while busy; an optional ignored start is injected at k == inject_at.
    task automatic wait_done(input string nm, input int inject_at);
        int lat = -1;
        bit busy_bad = 1'b0;
        bit hold_bad = 1'b0;
        for (int k = 0; k <= M + 8; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done === 1'b1) begin
                lat = k;
                break;
            end
            if (ready !== 1'b0) busy_bad = 1'b1;
            if (product !== last_p) hold_bad = 1'b1;
            if (k == inject_at) begin
                start = 1'b1; quotient = 1; divisor = 1; remainder = 0;
            end else begin
                start = 1'b0;
                t32 = $urandom; quotient  = t32[M-1:0];
                t32 = $urandom; divisor   = t32[N-1:0];
                t32 = $urandom; remainder = t32[N-1:0];
            end
        end
        start = 1'b0;
        chk({nm, "_latency"}, 64'(lat), 64'(M + 1));
        chk({nm, "_busy"}, 64'(busy_bad), 64'd0);
        chk({nm, "_hold"}, 64'(hold_bad), 64'd0);
        chk({nm, "_ready_done"}, 64'(ready), 64'd1);
    endtask

    task automatic do_op(input string nm, input logic [M-1:0] q, input logic [N-1:0] d,
                         input logic [N-1:0] r, input logic [W-1:0] ep, input logic ee,
                         input int inject_at);
        chk({nm, "_ready"}, 64'(ready), 64'd1);
        quotient = q; divisor = d; remainder = r; start = 1'b1;
        wait_done(nm, inject_at);
        chk({nm, "_product"}, 64'(product), 64'(ep));
        chk({nm, "_rem_err"}, 64'(rem_err), 64'(ee));
        last_p = ep;
    endtask

    task automatic watch_no_done(input string nm, input int cycles);
        bit seen = 1'b0;
        for (int k = 0; k < cycles; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done !== 1'b0) seen = 1'b1;
        end
        chk({nm, "_no_done"}, 64'(seen), 64'd0);
    endtask

    initial begin
        tbl[0] = '{"basic",   26'd1000,      14'd7,     14'd3,     40'd7003,          1'b0};
        tbl[1] = '{"max",     26'h3FF_FFFF,  14'd16383, 14'd16382, 40'hFF_FBFF_FFFF,  1'b0};
        tbl[2] = '{"div0",    26'd5,         14'd0,     14'd9,     40'd9,             1'b1};
        tbl[3] = '{"zeros",   26'd0,         14'd0,     14'd0,     40'd0,             1'b1};
        tbl[4] = '{"q0",      26'd0,         14'd123,   14'd5,     40'd5,             1'b0};
        tbl[5] = '{"r_eq_d",  26'd1,         14'd16383, 14'd16383, 40'd32766,         1'b1};
        tbl[6] = '{"d1",      26'h3FF_FFFF,  14'd1,     14'd0,     40'h00_03FF_FFFF,  1'b0};

        rst = 1'b1; start = 1'b0; quotient = '0; divisor = '0; remainder = '0;
        last_p = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready",   64'(ready),   64'd1);
        chk("rst_done",    64'(done),    64'd0);
        chk("rst_product", 64'(product), 64'd0);
        chk("rst_rem_err", 64'(rem_err), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Table vectors, each followed by a done-pulse-width / hold check.
        for (int i = 0; i < 7; i++) begin
            do_op(tbl[i].name, tbl[i].q, tbl[i].d, tbl[i].r, tbl[i].p, tbl[i].e, -1);
            @(posedge clk);
            @(negedge clk);
            chk({tbl[i].name, "_done_pulse"}, 64'(done), 64'd0);
            chk({tbl[i].name, "_held"}, 64'(product), 64'(tbl[i].p));
        end

        // Ignored start while busy, then a start in the done cycle.
        do_op("busy", 26'd12, 14'd34, 14'd5, 40'd413, 1'b0, 10);
        do_op("b2b",  26'd3,  14'd3,  14'd1, 40'd10,  1'b0, -1);
        @(negedge clk);

        // Reset in the middle of an operation.
        quotient = 26'd100; divisor = 14'd100; remainder = 14'd0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (14) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        last_p = '0;
        chk("midrst_done",    64'(done),    64'd0);
        chk("midrst_product", 64'(product), 64'd0);
        chk("midrst_rem_err", 64'(rem_err), 64'd0);
        chk("midrst_ready",   64'(ready),   64'd1);
        watch_no_done("midrst", 35);
        do_op("after_rst", 26'd2, 14'd3, 14'd1, 40'd7, 1'b0, -1);
        @(negedge clk);

        // rst and start together: start is dropped.
        quotient = 26'd9; divisor = 14'd9; remainder = 14'd9; start = 1'b1; rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; rst = 1'b0;
        last_p = '0;
        chk("rststart_ready",   64'(ready),   64'd1);
        chk("rststart_product", 64'(product), 64'd0);
        watch_no_done("rststart", 35);

        // Random operands against the arithmetic model.
        for (int i = 0; i < 150; i++) begin
            t32 = $urandom; rq = t32[M-1:0];
            t32 = $urandom; rd = t32[N-1:0];
            t32 = $urandom; rr = t32[N-1:0];
            if (i % 10 == 0) rd = '0;
            e64 = {38'd0, rq} * {50'd0, rd} + {50'd0, rr};
            do_op("rand", rq, rd, rr, e64[W-1:0], (rr >= rd), -1);
        end

        // Divider round trip: dividend = q*d + r with r < d.
        for (int i = 0; i < 1000; i++) begin
            t32 = $urandom; a32 = {6'd0, t32[M-1:0]};
            b32 = $urandom_range(16383, 1);
            t32 = a32 / b32; rq = t32[M-1:0];
            t32 = a32 % b32; rr = t32[N-1:0];
            rd = b32[N-1:0];
            do_op("roundtrip", rq, rd, rr, {14'd0, a32[M-1:0]}, 1'b0, -1);
        end

        flag = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
